// File: rtl/demux_npu.sv
// Buffered one-to-N demultiplexer: one valid/ready flit stream fanned out to N ports, each behind a 2-entry FIFO.
// Optional `DEMUX_NPU_DEST_CHECK_EN drops non-one-hot destinations and raises a sticky o_error.
module demux_npu #(
  parameter int N     = 4,
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_valid,
  input  logic [N-1:0]       i_dest,
  input  logic [WIDTH-1:0]   i_data,
  output logic               o_ready,
  output logic [N-1:0]       o_valid,
  output logic [N*WIDTH-1:0] o_data,
  input  logic [N-1:0]       i_port_ready,
  output logic               o_error
);

  localparam int IW = $clog2(N);

  logic [1:0]       cnt  [N];
  logic             wptr [N];
  logic             rptr [N];
  logic [WIDTH-1:0] mem  [N][2];

  logic [IW-1:0] tgt;
  logic          drop;
  logic          push;
  logic [N-1:0]  pop;

  // Last set bit wins, so multi-hot destinations resolve to the MSB.
  always_comb begin
    tgt = '0;
    for (int k = 0; k < N; k++) begin
      if (i_dest[k]) tgt = IW'(k);
    end
  end

`ifdef DEMUX_NPU_DEST_CHECK_EN
  assign drop = !$onehot(i_dest);
`else
  assign drop = (i_dest == '0);
`endif

  assign o_ready = drop || (cnt[tgt] != 2'd2);
  assign push    = i_valid && o_ready && !drop;

  always_comb begin
    pop = '0;
    for (int k = 0; k < N; k++) begin
      o_valid[k]                  = (cnt[k] != 2'd0);
      o_data[k*WIDTH +: WIDTH]    = mem[k][rptr[k]];
      pop[k]                      = o_valid[k] && i_port_ready[k];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < N; k++) begin
        cnt[k]  <= 2'd0;
        wptr[k] <= 1'b0;
        rptr[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        if (push && (tgt == IW'(k)) && !pop[k]) cnt[k] <= cnt[k] + 2'd1;
        else if (pop[k] && !(push && (tgt == IW'(k)))) cnt[k] <= cnt[k] - 2'd1;
        if (push && (tgt == IW'(k))) wptr[k] <= ~wptr[k];
        if (pop[k]) rptr[k] <= ~rptr[k];
      end
    end
  end

  // Flit storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[tgt][wptr[tgt]] <= i_data;
  end

`ifdef DEMUX_NPU_DEST_CHECK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              o_error <= 1'b0;
    else if (i_valid && drop)  o_error <= 1'b1;
  end
`else
  assign o_error = 1'b0;
`endif

endmodule

// File: tb/tb_demux_npu.sv
// Self-checking bench for demux_npu: per-port queue model, directed scenarios and a random soak.
module tb_demux_npu;
  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           i_valid = 1'b0;
  logic [N-1:0]   i_dest = '0;
  logic [W-1:0]   i_data = '0;
  logic           o_ready;
  logic [N-1:0]   o_valid;
  logic [N*W-1:0] o_data;
  logic [N-1:0]   i_port_ready = '0;
  logic           o_error;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] q [N][$];
  logic         exp_err = 1'b0;

  demux_npu #(.N(N), .WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .i_valid(i_valid), .i_dest(i_dest),
    .i_data(i_data), .o_ready(o_ready), .o_valid(o_valid), .o_data(o_data),
    .i_port_ready(i_port_ready), .o_error(o_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Destination port for a flit, or -1 if the flit is dropped.
  function automatic int tgt_of(input logic [N-1:0] d);
`ifdef DEMUX_NPU_DEST_CHECK_EN
    if ($countones(d) != 1) return -1;
`else
    if (d == '0) return -1;
`endif
    for (int i = N - 1; i >= 0; i--) if (d[i]) return i;
    return -1;
  endfunction

  function automatic logic [W-1:0] port_data(input int k);
    return o_data[k*W +: W];
  endfunction

  // Reference model: advances on every rising edge outside reset.
  always @(posedge clk) begin
    int  t;
    logic acc;
    if (reset_n) begin
      t   = tgt_of(i_dest);
      acc = i_valid && (t < 0 || q[t].size() < 2);
`ifdef DEMUX_NPU_DEST_CHECK_EN
      if (i_valid && t < 0) exp_err = 1'b1;
`endif
      for (int k = 0; k < N; k++)
        if (q[k].size() > 0 && i_port_ready[k]) void'(q[k].pop_front());
      if (acc && t >= 0) q[t].push_back(i_data);
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    int   t;
    logic er;
    t  = tgt_of(i_dest);
    er = (t < 0) || (q[t].size() < 2);
    chk("o_ready", {63'd0, o_ready}, {63'd0, er});
    chk("o_error", {63'd0, o_error}, {63'd0, exp_err});
    for (int k = 0; k < N; k++) begin
      chk("o_valid", {63'd0, o_valid[k]}, {63'd0, q[k].size() != 0});
      if (q[k].size() != 0) chk("o_data", {32'd0, port_data(k)}, {32'd0, q[k][0]});
    end
  end

  task automatic drive(input logic v, input logic [N-1:0] d, input logic [W-1:0] x, input logic [N-1:0] pr);
    i_valid = v; i_dest = d; i_data = x; i_port_ready = pr;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic flush_model();
    for (int k = 0; k < N; k++) q[k].delete();
    exp_err = 1'b0;
  endtask

  initial begin
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    flush_model();
    #1;
    chk("rst_valid", {60'd0, o_valid}, 64'd0);
    chk("rst_ready", {63'd0, o_ready}, 64'd1);
    chk("rst_error", {63'd0, o_error}, 64'd0);
    step(); step();
    reset_n = 1'b1;

    // Basic routing
    drive(1'b1, 4'b0100, 32'hA5A5_0001, 4'b1111);
    @(negedge clk); chk("basic_ready", {63'd0, o_ready}, 64'd1);
    step(); drive(1'b0, 4'b0000, 32'h0, 4'b1111);
    @(negedge clk);
    chk("basic_valid", {60'd0, o_valid}, 64'h4);
    chk("basic_data", {32'd0, port_data(2)}, 64'hA5A5_0001);
    step();
    @(negedge clk); chk("basic_popped", {60'd0, o_valid}, 64'd0);
    step();

    // Backpressure on port 1
    drive(1'b1, 4'b0010, 32'hD1, 4'b1101);
    @(negedge clk); chk("bp_ready1", {63'd0, o_ready}, 64'd1);
    step(); drive(1'b1, 4'b0010, 32'hD2, 4'b1101);
    @(negedge clk); chk("bp_ready2", {63'd0, o_ready}, 64'd1);
    step(); drive(1'b1, 4'b0010, 32'hD3, 4'b1101);
    @(negedge clk); chk("bp_ready3", {63'd0, o_ready}, 64'd0);
    step(); drive(1'b1, 4'b0010, 32'hD3, 4'b1111);
    @(negedge clk);
    chk("bp_full_ready", {63'd0, o_ready}, 64'd0);
    chk("bp_head1", {32'd0, port_data(1)}, 64'hD1);
    step();
    @(negedge clk);
    chk("bp_ready_after_pop", {63'd0, o_ready}, 64'd1);
    chk("bp_head2", {32'd0, port_data(1)}, 64'hD2);
    step(); drive(1'b0, 4'b0000, 32'h0, 4'b1111);
    @(negedge clk);
    chk("bp_head3", {32'd0, port_data(1)}, 64'hD3);
    step(); step();

    // Port independence
    drive(1'b1, 4'b0001, 32'hE1, 4'b0000); step();
    drive(1'b1, 4'b0001, 32'hE2, 4'b0000); step();
    drive(1'b1, 4'b1000, 32'hF1, 4'b0000);
    @(negedge clk); chk("ind_ready", {63'd0, o_ready}, 64'd1);
    step(); drive(1'b0, 4'b0000, 32'h0, 4'b0000);
    @(negedge clk);
    chk("ind_valid", {60'd0, o_valid}, 64'h9);
    chk("ind_p0", {32'd0, port_data(0)}, 64'hE1);
    chk("ind_p3", {32'd0, port_data(3)}, 64'hF1);
    drive(1'b0, 4'b0000, 32'h0, 4'b1111);
    step(); step(); step();

    // Malformed destination
    drive(1'b1, 4'b0110, 32'h61, 4'b0000);
    @(negedge clk); chk("mal_ready", {63'd0, o_ready}, 64'd1);
    step(); drive(1'b0, 4'b0000, 32'h0, 4'b0000);
    @(negedge clk);
`ifdef DEMUX_NPU_DEST_CHECK_EN
    chk("mal_valid", {60'd0, o_valid}, 64'd0);
    chk("mal_error", {63'd0, o_error}, 64'd1);
`else
    chk("mal_valid", {60'd0, o_valid}, 64'h4);
    chk("mal_data", {32'd0, port_data(2)}, 64'h61);
    chk("mal_error", {63'd0, o_error}, 64'd0);
`endif
    drive(1'b1, 4'b0000, 32'h62, 4'b1111);
    @(negedge clk); chk("zero_ready", {63'd0, o_ready}, 64'd1);
    step(); drive(1'b0, 4'b0000, 32'h0, 4'b1111);
    @(negedge clk); chk("zero_valid", {60'd0, o_valid}, 64'd0);
    step();

    // Mid-stream reset with ports 0 and 2 full
    drive(1'b1, 4'b0001, 32'h01, 4'b0000); step();
    drive(1'b1, 4'b0001, 32'h02, 4'b0000); step();
    drive(1'b1, 4'b0100, 32'h21, 4'b0000); step();
    drive(1'b1, 4'b0100, 32'h22, 4'b0000); step();
    drive(1'b0, 4'b0000, 32'h0, 4'b1111);
    @(negedge clk); chk("pre_rst_valid", {60'd0, o_valid}, 64'h5);
    #1 reset_n = 1'b0;
    flush_model();
    #1;
    chk("mid_rst_valid", {60'd0, o_valid}, 64'd0);
    chk("mid_rst_error", {63'd0, o_error}, 64'd0);
    step(); reset_n = 1'b1;
    drive(1'b1, 4'b0001, 32'h0BAD_F00D, 4'b0000);
    step(); drive(1'b0, 4'b0000, 32'h0, 4'b0000);
    @(negedge clk);
    chk("post_rst_valid", {60'd0, o_valid}, 64'h1);
    chk("post_rst_data", {32'd0, port_data(0)}, 64'h0BAD_F00D);
    step();

    // Random soak
    for (int c = 0; c < 10000; c++) begin
      logic [N-1:0] d;
      logic [W-1:0] x;
      x = $urandom();
      if ($urandom_range(0, 7) < 6) d = N'(1) << $urandom_range(0, N - 1);
      else d = N'($urandom());
      drive($urandom_range(0, 3) != 0, d, x, N'($urandom()));
      step();
    end
    drive(1'b0, 4'b0000, 32'h0, 4'b1111);
    for (int c = 0; c < 4; c++) step();
    @(negedge clk); chk("drain_valid", {60'd0, o_valid}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
